// File: rtl/dm_pkg.sv
// Shared debug-module types: DMI op/error codes, DTMCS layout, DMI bus payloads
// and the DTM sequencer state.
package dm_pkg;

   localparam int DmiDataWidth = 32;
   localparam int DmiAddrWidthDefault = 7;

   typedef enum logic [1:0] {
      DmiNop   = 2'd0,
      DmiRead  = 2'd1,
      DmiWrite = 2'd2
   } dmi_op_e;

   typedef enum logic [1:0] {
      DmiErrNone   = 2'd0,
      DmiErrFailed = 2'd2,
      DmiErrBusy   = 2'd3
   } dmi_err_e;

   typedef struct packed {
      logic [31:18] zero1;
      logic         dmihardreset;
      logic         dmireset;
      logic         zero0;
      logic [2:0]   idle;
      logic [1:0]   dmistat;
      logic [5:0]   abits;
      logic [3:0]   version;
   } dtmcs_t;

   typedef struct packed {
      logic [DmiAddrWidthDefault-1:0] addr;
      logic [DmiDataWidth-1:0]        data;
      dmi_op_e                        op;
   } dmi_req_t;

   typedef struct packed {
      logic [DmiDataWidth-1:0] data;
      logic [1:0]              resp;
   } dmi_resp_t;

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StRead      = 3'd1,
      StWrite     = 3'd2,
      StWaitRead  = 3'd3,
      StWaitWrite = 3'd4
   } dtm_state_e;

   // Observation bundle for the sequencer: current state and sticky error.
   typedef struct packed {
      dtm_state_e state;
      logic [1:0] error;
   } dtm_dbg_t;

endpackage

// File: rtl/dtm_dmi_ctrl_if.sv
// DMI request/response bus between the DTM (master) and the Debug Module (slave).
// Both channels: a transfer happens on a rising edge where valid and ready are both
// high; the sender holds valid and payload stable until then and never waits on ready.
interface dtm_dmi_ctrl_if #(
   parameter int AddrWidth = 7
) ();
   logic                 req_valid;
   logic                 req_ready;
   logic [AddrWidth-1:0] req_addr;
   logic [31:0]          req_data;
   logic [1:0]           req_op;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [31:0]          resp_data;
   logic [1:0]           resp_resp;

   modport master (
      output req_valid, req_addr, req_data, req_op, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_resp
   );

   modport slave (
      input  req_valid, req_addr, req_data, req_op, resp_ready,
      output req_ready, resp_valid, resp_data, resp_resp
   );
endinterface

// File: rtl/dtm_dmi_ctrl.sv
// JTAG DTM core: DTMCS/DMI data registers and the one-outstanding-request DMI
// sequencer, all in the TCK domain.
module dtm_dmi_ctrl
   import dm_pkg::*;
#(
   parameter int         AddrWidth  = 7,
   parameter logic [2:0] IdleHint   = 3'd1,
   parameter logic [3:0] DtmVersion = 4'd1
) (
   input  logic           tck_i,
   input  logic           trst_ni,
   input  logic           dmi_clear_i,
   input  logic           capture_i,
   input  logic           shift_i,
   input  logic           update_i,
   input  logic           tdi_i,
   input  logic           dtmcs_select_i,
   output logic           dtmcs_tdo_o,
   input  logic           dmi_select_i,
   output logic           dmi_tdo_o,
   output logic           dmi_rst_no,
   output dtm_dbg_t       dbg_o,
   dtm_dmi_ctrl_if.master dmi
);

   localparam int SrWidth = AddrWidth + 34;

   logic [31:0]          dtmcs_sr;
   logic [SrWidth-1:0]   dmi_sr;
   dtm_state_e           state_q;
   logic [1:0]           error_q, error_d;
   logic [AddrWidth-1:0] address_q;
   logic [31:0]          data_q;
   logic                 req_valid_q, resp_ready_q, rst_n_q;
   logic [1:0]           req_op_q;
   dtmcs_t               dtmcs_cap;

   logic dtmcs_update, dmi_capture, dmi_update, dmi_busy, hard_reset, resp_fire, dmi_start;

   assign dtmcs_update = dtmcs_select_i & update_i;
   assign dmi_capture  = dmi_select_i & capture_i;
   assign dmi_update   = dmi_select_i & update_i;
   assign dmi_busy     = (state_q != StIdle);
   assign hard_reset   = dtmcs_update & dtmcs_sr[17];
   assign resp_fire    = resp_ready_q & dmi.resp_valid;
   assign dmi_start    = dmi_update & (error_q == DmiErrNone) & ~dmi_busy;

   always_comb begin
      dtmcs_cap         = '0;
      dtmcs_cap.idle    = IdleHint;
      dtmcs_cap.dmistat = error_q;
      dtmcs_cap.abits   = 6'(AddrWidth);
      dtmcs_cap.version = DtmVersion;
   end

   // Busy is raised before a failed response is considered, so a capture that
   // reported op=3 to the host is never overwritten in the same edge.
   always_comb begin
      error_d = error_q;
      if ((dmi_capture || dmi_update) && dmi_busy && error_d == DmiErrNone) error_d = DmiErrBusy;
      if (resp_fire && dmi.resp_resp != 2'd0 && error_d == DmiErrNone) error_d = DmiErrFailed;
      if (dtmcs_update && dtmcs_sr[16]) error_d = DmiErrNone;
   end

   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         dtmcs_sr <= '0;
         dmi_sr   <= '0;
      end else if (dmi_clear_i) begin
         dtmcs_sr <= '0;
         dmi_sr   <= '0;
      end else begin
         if (dtmcs_select_i) begin
            if (capture_i)    dtmcs_sr <= dtmcs_cap;
            else if (shift_i) dtmcs_sr <= {tdi_i, dtmcs_sr[31:1]};
         end
         if (dmi_select_i) begin
            if (capture_i)    dmi_sr <= {address_q, data_q, dmi_busy ? 2'd3 : error_q};
            else if (shift_i) dmi_sr <= {tdi_i, dmi_sr[SrWidth-1:1]};
         end
      end
   end

   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         state_q      <= StIdle;
         error_q      <= '0;
         address_q    <= '0;
         data_q       <= '0;
         req_valid_q  <= 1'b0;
         req_op_q     <= '0;
         resp_ready_q <= 1'b0;
         rst_n_q      <= 1'b1;
      end else if (dmi_clear_i) begin
         state_q      <= StIdle;
         error_q      <= '0;
         address_q    <= '0;
         data_q       <= '0;
         req_valid_q  <= 1'b0;
         req_op_q     <= '0;
         resp_ready_q <= 1'b0;
         rst_n_q      <= 1'b1;
      end else if (hard_reset) begin
         state_q      <= StIdle;
         error_q      <= '0;
         req_valid_q  <= 1'b0;
         req_op_q     <= '0;
         resp_ready_q <= 1'b0;
         rst_n_q      <= 1'b0;
      end else begin
         rst_n_q <= 1'b1;
         error_q <= error_d;
         case (state_q)
            StIdle: begin
               if (dmi_start) begin
                  address_q <= dmi_sr[SrWidth-1 -: AddrWidth];
                  if (dmi_sr[1:0] == DmiRead) begin
                     state_q     <= StRead;
                     req_valid_q <= 1'b1;
                     req_op_q    <= DmiRead;
                  end else if (dmi_sr[1:0] == DmiWrite) begin
                     data_q      <= dmi_sr[33:2];
                     state_q     <= StWrite;
                     req_valid_q <= 1'b1;
                     req_op_q    <= DmiWrite;
                  end
               end
            end
            StRead, StWrite: begin
               if (dmi.req_ready) begin
                  state_q      <= (state_q == StRead) ? StWaitRead : StWaitWrite;
                  req_valid_q  <= 1'b0;
                  req_op_q     <= '0;
                  resp_ready_q <= 1'b1;
               end
            end
            StWaitRead, StWaitWrite: begin
               if (dmi.resp_valid) begin
                  if (state_q == StWaitRead) data_q <= dmi.resp_data;
                  state_q      <= StIdle;
                  resp_ready_q <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign dmi.req_valid  = req_valid_q;
   assign dmi.req_addr   = address_q;
   assign dmi.req_data   = data_q;
   assign dmi.req_op     = req_op_q;
   assign dmi.resp_ready = resp_ready_q;
   assign dtmcs_tdo_o    = dtmcs_sr[0];
   assign dmi_tdo_o      = dmi_sr[0];
   assign dmi_rst_no     = rst_n_q;
   assign dbg_o          = '{state: state_q, error: error_q};

endmodule
